// File: rtl/spi_flash_rd.sv
// ============================================================================
//  Module      : spi_flash_rd
//  Description : Autonomous serial-flash READ sequencer.  Acts as bus master
//                of an SPI master register block.  It programs the divider,
//                drops flash chip-select, then pushes the command, the 24-bit
//                address (and a dummy byte in fast-read builds) followed by one
//                0x00 fill byte per requested byte, and streams every received
//                data byte out on rdata/rvalid.
//                Build option: define FLASH_FAST_READ_EN for command 0x0B with
//                one dummy byte; otherwise command 0x03 without dummy.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_flash_rd #(
    parameter int             DW       = 32,
    parameter logic [DW-1:0]  SPI_BASE = '0,
    parameter int             DIV_LOG2 = 1,
    parameter int             LENW     = 16,
    parameter int             CS_GAP   = 4
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic [23:0]     req_adrs,
    input  logic [LENW-1:0] req_len,
    output logic            busy,
    output logic [7:0]      rdata,
    output logic            rvalid,
    output logic            done,
    output logic            flash_csn,
    output logic            m_cs,
    output logic            m_rd,
    output logic            m_we,
    output logic [DW-1:0]   m_adrs,
    output logic [DW-1:0]   m_din,
    input  logic [DW-1:0]   m_dout
);

`ifdef FLASH_FAST_READ_EN
    localparam int          HDR_N = 5;
    localparam logic [7:0]  CMD   = 8'h0B;
`else
    localparam int          HDR_N = 4;
    localparam logic [7:0]  CMD   = 8'h03;
`endif

    localparam int             GAPW   = $clog2(CS_GAP + 1);
    localparam logic [DW-1:0]  A_DATA = SPI_BASE;
    localparam logic [DW-1:0]  A_STAT = SPI_BASE + DW'(4);
    localparam logic [DW-1:0]  A_DIV  = SPI_BASE + DW'(8);

    typedef enum logic [2:0] {
        S_INIT = 3'd0,
        S_IDLE = 3'd1,
        S_POLL = 3'd2,
        S_CHK  = 3'd3,
        S_WR   = 3'd4,
        S_RD   = 3'd5,
        S_CAP  = 3'd6,
        S_GAP  = 3'd7
    } state_t;

    state_t                 state_q;
    logic                   busy_q;
    logic                   rvalid_q;
    logic                   done_q;
    logic [7:0]             rdata_q;
    logic                   csn_q;
    logic                   cs_q;
    logic                   rd_q;
    logic                   we_q;
    logic [DW-1:0]          adrs_q;
    logic [DW-1:0]          din_q;
    logic [LENW-1:0]        len_q;       // fill bytes still to be sent
    logic [HDR_N*8-1:0]     hdr_q;       // header bytes, next one in the top byte
    logic [2:0]             hdr_left_q;  // header bytes still to be sent
    logic                   last_data_q; // byte on the wire is a data byte
    logic [GAPW-1:0]        gap_q;

    logic                   pending_d;
    logic [7:0]             byte_d;
    logic                   wr_d;
    logic                   fin_d;
    logic                   stat_idle;
    logic                   unused_dout_bits;

    assign stat_idle = m_dout[0];
    assign pending_d = (hdr_left_q != 3'd0) || (len_q != '0);
    assign byte_d    = (hdr_left_q != 3'd0) ? hdr_q[HDR_N*8-1 -: 8] : 8'h00;

    // The received byte must be picked up before another byte is launched, so
    // a finished data byte always goes through RD/CAP first.
    assign wr_d  = ((state_q == S_CHK) && stat_idle && !last_data_q && pending_d) ||
                   ((state_q == S_CAP) && pending_d);
    assign fin_d = ((state_q == S_CHK) && stat_idle && !last_data_q && !pending_d) ||
                   ((state_q == S_CAP) && !pending_d);

    assign unused_dout_bits = |m_dout[DW-1:8];

    assign busy      = busy_q;
    assign rdata     = rdata_q;
    assign rvalid    = rvalid_q;
    assign done      = done_q;
    assign flash_csn = csn_q;
    assign m_cs      = cs_q;
    assign m_rd      = rd_q;
    assign m_we      = we_q;
    assign m_adrs    = adrs_q;
    assign m_din     = din_q;

    // Sequencer: every bus strobe is registered and launched on entry to its state.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= S_INIT;
            busy_q      <= 1'b1;
            rvalid_q    <= 1'b0;
            done_q      <= 1'b0;
            rdata_q     <= 8'h00;
            csn_q       <= 1'b1;
            cs_q        <= 1'b0;
            rd_q        <= 1'b0;
            we_q        <= 1'b0;
            adrs_q      <= SPI_BASE;
            din_q       <= '0;
            len_q       <= '0;
            hdr_q       <= '0;
            hdr_left_q  <= 3'd0;
            last_data_q <= 1'b0;
            gap_q       <= '0;
        end else begin
            cs_q     <= 1'b0;
            rd_q     <= 1'b0;
            we_q     <= 1'b0;
            rvalid_q <= 1'b0;
            done_q   <= 1'b0;

            unique case (state_q)
                S_INIT: begin
                    cs_q    <= 1'b1;
                    we_q    <= 1'b1;
                    adrs_q  <= A_DIV;
                    din_q   <= DW'(DIV_LOG2);
                    state_q <= S_IDLE;
                end
                S_IDLE: begin
                    csn_q <= 1'b1;
                    if (!busy_q && start && (req_len != '0)) begin
`ifdef FLASH_FAST_READ_EN
                        hdr_q <= {CMD, req_adrs, 8'h00};
`else
                        hdr_q <= {CMD, req_adrs};
`endif
                        hdr_left_q <= 3'(HDR_N);
                        len_q      <= req_len;
                        csn_q      <= 1'b0;
                        busy_q     <= 1'b1;
                        cs_q       <= 1'b1;
                        rd_q       <= 1'b1;
                        adrs_q     <= A_STAT;
                        state_q    <= S_POLL;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                S_POLL: begin
                    state_q <= S_CHK;
                end
                S_CHK: begin
                    if (!stat_idle) begin
                        cs_q    <= 1'b1;
                        rd_q    <= 1'b1;
                        adrs_q  <= A_STAT;
                        state_q <= S_POLL;
                    end else if (last_data_q) begin
                        cs_q    <= 1'b1;
                        rd_q    <= 1'b1;
                        adrs_q  <= A_DATA;
                        state_q <= S_RD;
                    end
                end
                S_WR: begin
                    cs_q    <= 1'b1;
                    rd_q    <= 1'b1;
                    adrs_q  <= A_STAT;
                    state_q <= S_POLL;
                end
                S_RD: begin
                    state_q <= S_CAP;
                end
                S_CAP: begin
                    rdata_q     <= m_dout[7:0];
                    rvalid_q    <= 1'b1;
                    last_data_q <= 1'b0;
                end
                S_GAP: begin
                    if (gap_q <= GAPW'(1)) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        gap_q <= gap_q - GAPW'(1);
                    end
                end
                default: begin
                    state_q <= S_INIT;
                end
            endcase

            // Launch the next byte (header byte or 0x00 fill byte).
            if (wr_d) begin
                cs_q    <= 1'b1;
                we_q    <= 1'b1;
                adrs_q  <= A_DATA;
                din_q   <= {{(DW-8){1'b0}}, byte_d};
                state_q <= S_WR;
                if (hdr_left_q != 3'd0) begin
                    hdr_q      <= hdr_q << 8;
                    hdr_left_q <= hdr_left_q - 3'd1;
                end else begin
                    len_q       <= len_q - LENW'(1);
                    last_data_q <= 1'b1;
                end
            end

            // Last data byte captured: release the flash and hold off for the gap.
            if (fin_d) begin
                csn_q   <= 1'b1;
                done_q  <= 1'b1;
                gap_q   <= GAPW'(CS_GAP);
                state_q <= S_GAP;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_spi_flash_rd.sv
// ============================================================================
//  Module      : tb_spi_flash_rd
//  Description : Self-checking bench for spi_flash_rd with a register-level
//                SPI master / flash model and a transaction-level reference.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_flash_rd;

    localparam int           DW     = 32;
    localparam logic [31:0]  BASE   = 32'h0000_0400;
    localparam int           DIV    = 1;
    localparam int           LENW   = 16;
    localparam int           CS_GAP = 4;
    localparam int           BUDGET = 20000;
`ifdef FLASH_FAST_READ_EN
    localparam int           HDR = 5;
    localparam logic [7:0]   CMD = 8'h0B;
`else
    localparam int           HDR = 4;
    localparam logic [7:0]   CMD = 8'h03;
`endif

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            start = 1'b0;
    logic [23:0]     req_adrs = '0;
    logic [LENW-1:0] req_len = '0;
    logic            busy, rvalid, done, flash_csn, m_cs, m_rd, m_we;
    logic [7:0]      rdata;
    logic [DW-1:0]   m_adrs, m_din;
    logic [DW-1:0]   m_dout = '0;

    spi_flash_rd #(
        .DW       (DW),
        .SPI_BASE (BASE),
        .DIV_LOG2 (DIV),
        .LENW     (LENW),
        .CS_GAP   (CS_GAP)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .req_adrs  (req_adrs),
        .req_len   (req_len),
        .busy      (busy),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .done      (done),
        .flash_csn (flash_csn),
        .m_cs      (m_cs),
        .m_rd      (m_rd),
        .m_we      (m_we),
        .m_adrs    (m_adrs),
        .m_din     (m_din),
        .m_dout    (m_dout)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // SPI master + flash model
    int          lat = 2;
    bit          echo_mode = 1'b0;
    int          slv_busy = 0;
    int          idx = 0;
    logic [7:0]  rhr = 8'h00;
    logic [7:0]  rnd_b;
    logic [7:0]  exp_rd[$];

    // Register-level SPI master: writes to +0 start a transfer lasting lat cycles.
    always @(posedge clk) begin
        if (m_cs && m_rd)
            m_dout <= (m_adrs == BASE + 32'd4) ? {31'b0, (slv_busy == 0)} : {24'b0, rhr};
        if (m_cs && m_we && m_adrs == BASE) begin
            slv_busy <= lat;
            if (idx >= HDR) begin
                rnd_b = echo_mode ? (8'hA0 + 8'(idx - HDR)) : 8'($urandom);
                rhr <= rnd_b;
                exp_rd.push_back(rnd_b);
            end else begin
                rhr <= 8'hFF;
            end
            idx <= idx + 1;
        end else if (slv_busy != 0) begin
            slv_busy <= slv_busy - 1;
        end
        if (flash_csn)
            idx <= 0;
    end

    // Observation of the DUT, sampled mid-cycle
    logic [7:0]  mosi_q[$];
    logic [7:0]  got_q[$];
    int          div_wr = 0;
    logic [31:0] div_val = '0;
    int          ovr = 0, proto = 0, done_cnt = 0, done_bad = 0, csn_low = 0;
    int          hi_busy = 0, gap_seen = 0;
    logic        csn_prev = 1'b1, busy_prev = 1'b1;

    always @(negedge clk) begin
        if ((m_rd || m_we) && !m_cs) proto++;
        if (m_rd && m_we) proto++;
        if (m_cs && m_we && m_adrs == BASE) begin
            mosi_q.push_back(m_din[7:0]);
            if (slv_busy != 0) ovr++;
            if (m_din[31:8] != 0) proto++;
        end
        if (m_cs && m_we && m_adrs == BASE + 32'd8) begin
            div_wr++;
            div_val = m_din;
        end
        if (rvalid) got_q.push_back(rdata);
        if (done) begin
            done_cnt++;
            if (!(flash_csn && !csn_prev)) done_bad++;
        end
        if (!flash_csn) begin
            csn_low++;
            hi_busy = 0;
        end else if (busy) begin
            hi_busy++;
        end
        if (busy_prev && !busy) gap_seen = hi_busy;
        csn_prev  = flash_csn;
        busy_prev = busy;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_obs();
        mosi_q.delete();
        got_q.delete();
        exp_rd.delete();
        div_wr = 0; ovr = 0; proto = 0; done_cnt = 0; done_bad = 0;
        csn_low = 0; gap_seen = 0;
    endtask

    task automatic wait_idle(input string tag);
        bit to = 1'b1;
        for (int c = 0; c < BUDGET; c++) begin
            @(negedge clk);
            if (!busy) begin
                to = 1'b0;
                break;
            end
        end
        check({tag, "_timeout"}, 32'(to), 32'd0);
    endtask

    // Expected MOSI stream for one READ: command, address, optional dummy, fills.
    function automatic logic [7:0] exp_mosi(input logic [23:0] a, input int i);
        if (i == 0) return CMD;
        if (i == 1) return a[23:16];
        if (i == 2) return a[15:8];
        if (i == 3) return a[7:0];
        return 8'h00;
    endfunction

    task automatic run_txn(input string tag, input logic [23:0] a, input int len,
                           input int l, input bit dbl);
        bit to = 1'b1;
        clear_obs();
        lat = l;
        @(negedge clk);
        req_adrs = a;
        req_len  = LENW'(len);
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < BUDGET; c++) begin
            @(negedge clk);
            if (dbl && c == 5) begin
                req_adrs = ~a;
                req_len  = LENW'(len + 3);
                start    = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (!busy) begin
                to = 1'b0;
                break;
            end
        end
        start = 1'b0;
        repeat (2) @(negedge clk);
        check({tag, "_timeout"}, 32'(to), 32'd0);
        check({tag, "_mosi_n"}, 32'(mosi_q.size()), 32'(HDR + len));
        for (int i = 0; i < mosi_q.size() && i < HDR + len; i++)
            check({tag, "_mosi"}, 32'(mosi_q[i]), 32'(exp_mosi(a, i)));
        check({tag, "_rvalid_n"}, 32'(got_q.size()), 32'(len));
        for (int k = 0; k < got_q.size() && k < len; k++)
            check({tag, "_rdata"}, 32'(got_q[k]),
                  echo_mode ? 32'(8'hA0 + 8'(k)) : (k < exp_rd.size() ? 32'(exp_rd[k]) : 32'hFFFF_FFFF));
        check({tag, "_done_n"}, 32'(done_cnt), 32'd1);
        check({tag, "_done_csn"}, 32'(done_bad), 32'd0);
        check({tag, "_overrun"}, 32'(ovr), 32'd0);
        check({tag, "_bus"}, 32'(proto), 32'd0);
        check({tag, "_gap"}, 32'(gap_seen >= CS_GAP), 32'd1);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_csn", 32'(flash_csn), 32'd1);
        check("rst_cs", 32'(m_cs), 32'd0);
        check("rst_rd", 32'(m_rd), 32'd0);
        check("rst_we", 32'(m_we), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_adrs", m_adrs, BASE);
        check("rst_din", m_din, 32'd0);

        // Divider programming after reset release
        clear_obs();
        rstn = 1'b1;
        wait_idle("init");
        repeat (2) @(negedge clk);
        check("init_div_n", 32'(div_wr), 32'd1);
        check("init_div_val", div_val, 32'(DIV));
        check("init_csn_low", 32'(csn_low), 32'd0);

        // Fixed pattern read
        echo_mode = 1'b1;
        run_txn("t123456", 24'h123456, 3, 2, 1'b0);
        echo_mode = 1'b0;

        // Slow SPI: status stays busy for 50 cycles per byte
        run_txn("slow", 24'hABCDEF, 2, 50, 1'b0);

        // Zero-length request is ignored
        clear_obs();
        @(negedge clk);
        req_adrs = 24'h777777;
        req_len  = '0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        check("len0_mosi", 32'(mosi_q.size()), 32'd0);
        check("len0_csn", 32'(csn_low), 32'd0);
        check("len0_done", 32'(done_cnt), 32'd0);
        check("len0_busy", 32'(busy), 32'd0);

        // Start while busy is ignored
        run_txn("dbl", 24'h0F00F0, 2, 3, 1'b1);

        // Fast-read style target address
        run_txn("a10", 24'h000010, 1, 1, 1'b0);

        // Randomized transactions
        for (int t = 0; t < 5; t++)
            run_txn("rnd", 24'($urandom), int'($urandom_range(1, 6)),
                    int'($urandom_range(1, 6)), 1'b0);

        // Reset in the middle of the second data byte
        clear_obs();
        lat = 3;
        @(negedge clk);
        req_adrs = 24'h55AA55;
        req_len  = LENW'(4);
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        begin
            bit to = 1'b1;
            for (int c = 0; c < BUDGET; c++) begin
                @(negedge clk);
                if (mosi_q.size() >= HDR + 2) begin
                    to = 1'b0;
                    break;
                end
            end
            check("mid_reach_timeout", 32'(to), 32'd0);
        end
        rstn = 1'b0;
        @(negedge clk);
        check("mid_csn", 32'(flash_csn), 32'd1);
        check("mid_cs", 32'(m_cs), 32'd0);
        check("mid_rvalid", 32'(rvalid), 32'd0);
        repeat (2) @(negedge clk);
        check("mid_busy", 32'(busy), 32'd1);
        div_wr = 0;
        rstn = 1'b1;
        wait_idle("mid_init");
        repeat (2) @(negedge clk);
        check("mid_done", 32'(done_cnt), 32'd0);
        check("mid_div_n", 32'(div_wr), 32'd1);
        run_txn("post_rst", 24'($urandom), 1, 2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/spi_flash_rd.md
Name: spi_flash_rd

Overview:
- Hardware sequencer that drives the SPI master register interface as its bus master and performs serial-flash READ transactions autonomously.
- A requester supplies a 24-bit flash address and a byte count. The block configures the divider, asserts flash chip-select, then sends command, address and optional dummy bytes. It clocks out fill bytes and streams received bytes back.
- Sits between a boot loader / XIP cache fill engine and the SPI master peripheral, so the CPU does not poll the SPI byte by byte.

Parameters:
- DW, 32, data/address width of the SPI master bus port.
- SPI_BASE, 32'h0, byte base address of the SPI master; THR/RHR at +0x00, status at +0x04, log2 divider at +0x08.
- DIV_LOG2, 1, value written to the divider register after reset (1 = clk/2).
- LENW, 16, width of the byte-count request field.
- CS_GAP, 4, minimum clk cycles flash_csn stays high between transactions (>=1).

Ports:
- clk  in  1  clock.
- rstn  in  1  reset; synchronous, active-low.
- start  in  1  one-cycle request pulse; sampled only when busy=0.
- req_adrs  in  24  flash byte address.
- req_len  in  LENW  number of bytes to read.
- busy  out  1  transaction (or init/gap) in progress.
- rdata  out  8  received flash byte.
- rvalid  out  1  one-cycle strobe, rdata valid.
- done  out  1  one-cycle strobe after the last byte, coincident with csn rising.
- flash_csn  out  1  flash chip-select, active-low.
- m_cs, m_rd, m_we  out  1 each  SPI master bus strobes.
- m_adrs  out  DW  SPI master byte address.
- m_din  out  DW  write data to the SPI master ({DW-8 zeros, byte}).
- m_dout  in  DW  read data from the SPI master; registered, valid the cycle after m_rd.

Behaviour:
- Reset values: busy=1, rvalid=0, done=0, rdata=0, flash_csn=1, m_cs/m_rd/m_we=0, m_adrs=SPI_BASE, m_din=0. FSM enters INIT.
- At most one bus access per cycle. Any cycle with m_rd or m_we has m_cs=1.
- INIT (1 cycle): write DIV_LOG2 to SPI_BASE+8, then go to IDLE.
- IDLE: busy=0, csn=1.
  - start with req_len!=0: latch adrs and len, csn<=0, busy<=1, byte queue = {0x03, A[23:16], A[15:8], A[7:0]}, go to POLL.
  - start with req_len==0: ignored, no strobes.
  - start while busy=1: ignored.
- Byte engine:
  - POLL: read SPI_BASE+4.
  - CHK: if m_dout[0]=0, go back to POLL.
  - If m_dout[0]=1:
    - If a byte is pending, go to WR: write byte to SPI_BASE+0, then POLL.
    - If the just-finished byte was a data byte, go to RD: read SPI_BASE+0. In CAP (next cycle), rdata<=m_dout[7:0] and pulse rvalid. Then continue with the next pending byte, or finish.
- Header bytes (cmd/addr/dummy) are not captured. Data phase sends 0x00 fill bytes, one per requested byte.
- Byte counter decrements on each data-byte write.
- Finish:
  - After the last data byte is captured: csn<=1, pulse done, load gap counter with CS_GAP.
  - GAP: busy stays 1 until the counter reaches 0, then go to IDLE.
- Timing: the first status poll after a write observes idle=0, so the bus never overwrites a transfer in flight.
- Total rvalid pulses per transaction equals req_len exactly.
- Max length is 2^LENW-1; flash address wrap beyond 0xFFFFFF is the flash's behaviour, not tracked here.
- Reset mid-transaction: next edge forces csn=1, clears strobes, goes to INIT. A partial transfer is abandoned and done is not pulsed.

Optional Feature:
- FLASH_FAST_READ_EN defined: command 0x0B, with one 0x00 dummy byte appended after A[7:0] (5 header bytes).
- Undefined: command 0x03, 4 header bytes, no dummy.

Test Plan:
- Reset release -> exactly one write of 0x01 to SPI_BASE+8, then busy falls. flash_csn=1 throughout.
- start, adrs=0x123456, len=3; SPI model echoes 0xA0,0xA1,0xA2 in data phase -> MOSI bytes 03 12 34 56 00 00 00. rvalid x3 with rdata A0,A1,A2. done coincides with csn rising. csn high >=4 cycles before busy=0.
- SPI model holds status idle=0 for 50 cycles per byte -> no write to +0x00 while idle=0. Data still correct.
- start with len=0 -> no bus writes, csn stays 1, no done. start while busy -> ignored, and only the first transaction's bytes appear.
- rstn low during the 2nd data byte -> csn=1 next cycle, no done. After release, INIT divider write repeats and a new len=1 read succeeds.
- FLASH_FAST_READ_EN, adrs=0x000010, len=1 -> MOSI 0B 00 00 10 00 00, one rvalid.
